aeonic_spi_master: RTL and testbench

Byte-wide serial-SRAM controller for the aeonic core. It sits between the core's memory request port and the `n_ss`/`sclk`/`mosi`/`miso` pins, and turns each single-byte read or write into one SPI mode-0 transaction. The supported command set is 23LC-style: READ 0x03 and WRITE 0x02, each followed by a 16-bit address. SCLK runs at clk/2, and one request is handled at a time.

---
 rtl/aeonic_spi_master_pkg.sv | 33 +++
 rtl/aeonic_spi_master.sv | 138 +++++++++++++
 tb/tb_aeonic_spi_master.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/aeonic_spi_master_pkg.sv
// ---------------------------------------------------------------------------
// aeonic_spi_master_pkg
// Shared definitions for the aeonic serial-SRAM SPI master:
//   - state_t      : controller state encoding (IDLE=0, SHIFT=1, END=2)
//   - DEF_*_CMD    : default 23LC-style opcodes (READ 0x03, WRITE 0x02)
//   - PHASE_COUNT  : SCLK half-periods per transaction (32 bits x 2 phases)
//   - build_frame  : assembles the 32-bit outgoing frame {cmd, addr, data}
// ---------------------------------------------------------------------------
package aeonic_spi_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_END   = 2'd2
    } state_t;

    localparam logic [7:0] DEF_READ_CMD  = 8'h03;
    localparam logic [7:0] DEF_WRITE_CMD = 8'h02;

    localparam int         PHASE_COUNT = 64;
    localparam logic [5:0] LAST_PHASE  = 6'(PHASE_COUNT - 1);

    // Reads carry a don't-care data byte; it is driven as zero.
    function automatic logic [31:0] build_frame(
        input logic [7:0]  cmd,
        input logic [15:0] addr,
        input logic [7:0]  wdata,
        input logic        we
    );
        return {cmd, addr, (we ? wdata : 8'h00)};
    endfunction

endpackage

// File: rtl/aeonic_spi_master.sv
// ---------------------------------------------------------------------------
// aeonic_spi_master
// Byte-wide serial-SRAM controller. Each accepted request becomes one SPI
// mode-0 transaction: 8-bit opcode, 16-bit address, 8-bit data, MSB first,
// with SCLK at clk/2. One request is handled at a time.
//
// Ports:
//   clk, rst     : system clock (rising edge), async active-high reset
//   req          : request; accepted on a clock edge where req && ready
//   we/addr/wdata: captured at the accept edge (1 = write, 0 = read)
//   ready        : high only while IDLE
//   rdata        : last read byte, held until the next read completes
//   rdata_valid  : one-cycle pulse when rdata updates (reads only)
//   done         : one-cycle pulse at the end of every transaction
//   n_ss,sclk,mosi: SPI pins, all straight from flops
//   miso         : SPI serial input
//   dbg_state    : current controller state, for observation only
//
// Handshake: a transfer happens on a rising clk edge where req and ready are
// both high. req while ready is low is ignored, never queued; the requester
// keeps req high until it sees ready. Inputs are only looked at on that edge.
// ---------------------------------------------------------------------------
module aeonic_spi_master
    import aeonic_spi_master_pkg::*;
#(
    parameter logic [7:0] READ_CMD  = DEF_READ_CMD,
    parameter logic [7:0] WRITE_CMD = DEF_WRITE_CMD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        ready,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    output logic        done,
    output logic        n_ss,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output state_t      dbg_state
);

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_shift;
    logic        r_we;
    logic        r_n_ss;
    logic        r_sclk;
    logic [7:0]  r_rdata;
    logic        r_rdata_valid;
    logic        r_done;

    logic [31:0] w_frame;
    logic [31:0] w_shift_next;

    assign w_frame      = build_frame(we ? WRITE_CMD : READ_CMD, addr, wdata, we);
    assign w_shift_next = {r_shift[30:0], miso};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 6'd0;
            r_shift       <= 32'd0;
            r_we          <= 1'b0;
            r_n_ss        <= 1'b1;
            r_sclk        <= 1'b0;
            r_rdata       <= 8'h00;
            r_rdata_valid <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done        <= 1'b0;
                    r_rdata_valid <= 1'b0;
                    if (req) begin
                        r_shift <= w_frame;
                        r_we    <= we;
                        r_cnt   <= 6'd0;
                        r_n_ss  <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (!r_cnt[0]) begin
                        // Even phase ends: raise SCLK, MOSI holds.
                        r_sclk <= 1'b1;
                    end else begin
                        // Odd phase ends: sample MISO, shift, drop SCLK.
                        r_sclk <= 1'b0;
                        if (r_cnt == LAST_PHASE) begin
                            // Clearing the shifter parks MOSI (its MSB) low
                            // for END and IDLE.
                            r_shift <= 32'd0;
                            r_n_ss  <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_END;
                            if (!r_we) begin
                                r_rdata       <= w_shift_next[7:0];
                                r_rdata_valid <= 1'b1;
                            end
                        end else begin
                            r_shift <= w_shift_next;
                        end
                    end
                end

                ST_END: begin
                    r_done        <= 1'b0;
                    r_rdata_valid <= 1'b0;
                    r_cnt         <= 6'd0;
                    r_state       <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // MOSI is the shifter MSB directly, so it only moves on the edge that
    // ends an odd phase, i.e. while SCLK is going low.
    assign mosi        = r_shift[31];
    assign n_ss        = r_n_ss;
    assign sclk        = r_sclk;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign done        = r_done;
    assign ready       = (r_state == ST_IDLE);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_aeonic_spi_master.sv
// ---------------------------------------------------------------------------
// tb_aeonic_spi_master
// Directed bench for aeonic_spi_master with a behavioural SPI slave that
// returns a chosen byte in the data phase of reads.
// ---------------------------------------------------------------------------
module tb_aeonic_spi_master;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ready;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic        done;
    logic        n_ss;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic [1:0]  dbg_state;

    int          n_vec;
    int          n_err;
    logic [7:0]  exp_rdata;

    aeonic_spi_master dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .ready       (ready),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .done        (done),
        .n_ss        (n_ss),
        .sclk        (sclk),
        .mosi        (mosi),
        .miso        (miso),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete transaction, starting with ready high. Cycle k of the loop
    // is observed at the falling edge inside cycle k (accept edge ends cycle 0).
    task automatic run_txn(input logic t_we, input logic [15:0] t_addr,
                           input logic [7:0] t_wdata, input logic [7:0] slave_byte,
                           input logic keep_req, input logic poke);
        logic [31:0] exp_stream;
        logic [31:0] mon;
        int          rises;
        int          viol;
        int          bad;
        int          idle_bad;
        int          i;
        logic        prev_sclk;
        logic        prev_mosi;

        exp_stream = {(t_we ? 8'h02 : 8'h03), t_addr, (t_we ? t_wdata : 8'h00)};
        we    = t_we;
        addr  = t_addr;
        wdata = t_wdata;
        req   = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_req) req = 1'b0;
        // inputs are free to change after the accept edge
        addr  = ~t_addr;
        wdata = ~t_wdata;
        we    = ~t_we;

        prev_sclk = 1'b0;
        prev_mosi = 1'b0;
        mon = 32'd0;
        rises = 0;
        viol = 0;
        bad = 0;
        for (int k = 1; k <= 66; k++) begin
            @(negedge clk);
            if (poke && k == 20) begin
                req  = 1'b1;
                addr = 16'hBEEF;
            end
            if (poke && k == 21) req = 1'b0;
            if (k <= 64) begin
                if (n_ss !== 1'b0 || ready !== 1'b0 || done !== 1'b0 ||
                    rdata_valid !== 1'b0) bad++;
                if (sclk !== ((k % 2 == 0) ? 1'b1 : 1'b0)) bad++;
                if (sclk === 1'b1 && mosi !== prev_mosi) viol++;
                if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                    rises++;
                    mon = {mon[30:0], mosi};
                end
                // slave: present bit i while SCLK is low
                if (k % 2 == 1) begin
                    i = (k - 1) / 2;
                    miso = (i >= 24) ? slave_byte[31 - i] : 1'b1;
                end
            end
            prev_sclk = sclk;
            prev_mosi = mosi;
            if (k == 1) check_val("state_shift", 32'(dbg_state), 32'd1);
            if (k == 65) begin
                if (!t_we) exp_rdata = slave_byte;
                check_val("c65_done", 32'(done), 32'd1);
                check_val("c65_rvalid", 32'(rdata_valid), t_we ? 32'd0 : 32'd1);
                check_val("c65_rdata", 32'(rdata), 32'(exp_rdata));
                check_val("c65_pins", {29'd0, n_ss, sclk, mosi}, 32'b100);
                check_val("state_end", 32'(dbg_state), 32'd2);
            end
            if (k == 66) begin
                check_val("c66_ready", 32'(ready), 32'd1);
                check_val("c66_pulses", {30'd0, done, rdata_valid}, 32'd0);
                check_val("c66_nss", 32'(n_ss), 32'd1);
                check_val("c66_rdata", 32'(rdata), 32'(exp_rdata));
            end
        end
        miso = 1'b0;
        check_val("mosi_stream", mon, exp_stream);
        check_val("sclk_rises", 32'(rises), 32'd32);
        check_val("mosi_stable", 32'(viol), 32'd0);
        check_val("shift_window", 32'(bad), 32'd0);

        if (poke) begin
            idle_bad = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (n_ss !== 1'b1 || ready !== 1'b1) idle_bad++;
            end
            check_val("poke_ignored", 32'(idle_bad), 32'd0);
        end
    endtask

    initial begin
        int pulses;
        n_vec = 0;
        n_err = 0;
        exp_rdata = 8'h00;
        rst = 1'b1;
        req = 1'b0;
        we = 1'b0;
        addr = 16'h0000;
        wdata = 8'h00;
        miso = 1'b0;

        repeat (3) @(negedge clk);
        check_val("rst_pins", {29'd0, n_ss, sclk, mosi}, 32'b100);
        check_val("rst_ready", 32'(ready), 32'd1);
        check_val("rst_rdata", 32'(rdata), 32'h00);
        check_val("rst_pulses", {30'd0, done, rdata_valid}, 32'd0);
        check_val("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // read, then write that must leave rdata alone
        run_txn(1'b0, 16'h1234, 8'h00, 8'hA5, 1'b0, 1'b0);
        run_txn(1'b1, 16'h00FF, 8'h5A, 8'hFF, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // back-to-back reads with req held; MSB/LSB alignment bytes
        run_txn(1'b0, 16'h8001, 8'h00, 8'h80, 1'b1, 1'b0);
        run_txn(1'b0, 16'h7FFE, 8'h00, 8'h01, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // request while busy is dropped
        run_txn(1'b0, 16'h4321, 8'h00, 8'hC3, 1'b0, 1'b1);

        // reset in the middle of SHIFT
        we = 1'b0;
        addr = 16'h5555;
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        exp_rdata = 8'h00;
        check_val("midrst_pins", {29'd0, n_ss, sclk, mosi}, 32'b100);
        check_val("midrst_ready", 32'(ready), 32'd1);
        check_val("midrst_done", 32'(done), 32'd0);
        check_val("midrst_rdata", 32'(rdata), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || rdata_valid !== 1'b0 || n_ss !== 1'b1) pulses++;
        end
        check_val("midrst_quiet", 32'(pulses), 32'd0);

        run_txn(1'b0, 16'h0001, 8'h00, 8'h3C, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
